// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM controller: bus widths, phase-counter width and FSM encoding.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int PHASE_CNT_W = 4;

  typedef logic [1:0]             state_t;
  typedef logic [PHASE_CNT_W-1:0] phase_cnt_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Half-word SRAM address for one phase of a 32-bit word access.
  function automatic logic [SRAM_ADDR_W-1:0] half_addr(input logic [SRAM_ADDR_W-2:0] word_idx,
                                                       input logic upper);
    return {word_idx, upper};
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus between the pipeline (master) and the SRAM controller (slave).
interface sram_controller_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] mem_result;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, address, data,
    input  mem_result, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, data,
    output mem_result, ready
  );

endinterface

// File: rtl/sram_phase_counter.sv
// Down-counter timing one SRAM phase: load on phase entry, tc flags the last cycle of the phase.
module sram_phase_counter
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  phase_cnt_t load_value,
  output logic       tc
);

  phase_cnt_t count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - phase_cnt_t'(1);
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into a low and a high 16-bit SRAM phase.
// Define SRAM_CTRL_ADDR_CHECK_EN to add the addr_err output and reject misaligned/out-of-range offsets.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       mem,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
`ifdef SRAM_CTRL_ADDR_CHECK_EN
  ,
  output logic                   addr_err
`endif
);

  localparam phase_cnt_t PHASE_LOAD = phase_cnt_t'(WAIT_CYCLES - 1);

  state_t                 state_reg;
  logic                   write_reg;
  logic [SRAM_DATA_W-1:0] data_hi_reg;
  logic [31:0]            mem_result_reg;
  logic [SRAM_ADDR_W-1:0] sram_addr_reg;
  logic [SRAM_DATA_W-1:0] sram_dq_out_reg;

  logic [31:0] offset;
  logic        req;
  logic        in_phase;
  logic        bad_addr;
  logic        cnt_load;
  logic        cnt_tc;

  assign offset   = mem.address - ADDR_BASE;
  assign req      = mem.mem_r_en | mem.mem_w_en;
  assign in_phase = (state_reg == ST_LOW) || (state_reg == ST_HIGH);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  assign bad_addr = (offset[31:19] != '0) || (offset[1:0] != 2'b00);

  // Rejected requests skip straight to DONE, so the flag lines up with that single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (state_reg == ST_IDLE) && req && bad_addr;
    end
  end
`else
  logic unused_offset_bits;
  assign bad_addr           = 1'b0;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
`endif

  assign cnt_load = ((state_reg == ST_IDLE) && req && !bad_addr) ||
                    ((state_reg == ST_LOW) && cnt_tc);

  sram_phase_counter u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .en         (in_phase),
    .load_value (PHASE_LOAD),
    .tc         (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      write_reg       <= 1'b0;
      data_hi_reg     <= '0;
      mem_result_reg  <= '0;
      sram_addr_reg   <= '0;
      sram_dq_out_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            // A simultaneous read+write request is treated as a write.
            write_reg   <= mem.mem_w_en;
            data_hi_reg <= mem.data[31:16];
            if (bad_addr) begin
              state_reg <= ST_DONE;
            end else begin
              state_reg     <= ST_LOW;
              sram_addr_reg <= half_addr(offset[18:2], 1'b0);
              if (mem.mem_w_en) begin
                sram_dq_out_reg <= mem.data[15:0];
              end
            end
          end
        end
        ST_LOW: begin
          if (cnt_tc) begin
            state_reg        <= ST_HIGH;
            sram_addr_reg[0] <= 1'b1;
            if (write_reg) begin
              sram_dq_out_reg <= data_hi_reg;
            end else begin
              mem_result_reg[15:0] <= sram_dq_in;
            end
          end
        end
        ST_HIGH: begin
          if (cnt_tc) begin
            state_reg <= ST_DONE;
            if (!write_reg) begin
              mem_result_reg[31:16] <= sram_dq_in;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_addr      = sram_addr_reg;
  assign sram_dq_out    = sram_dq_out_reg;
  assign sram_dq_oe     = in_phase && write_reg;
  assign sram_we_n      = !(in_phase && write_reg);
  assign sram_oe_n      = !(in_phase && !write_reg);

  assign mem.mem_result = mem_result_reg;
  assign mem.ready      = (state_reg == ST_DONE) || ((state_reg == ST_IDLE) && !req);

endmodule
